// File: rtl/fixed_defs_pkg.sv
// Shared Q3.12 fixed-point definitions for the arithmetic datapath
// (divider and multiplier).
package fixed_defs;

   localparam int WIDTH = 16;
   localparam int FRAC  = 12;

   localparam logic [WIDTH-1:0] Q_MAX = 16'h7FFF;
   localparam logic [WIDTH-1:0] Q_MIN = 16'h8000;
   localparam logic [WIDTH-1:0] ONE   = 16'h1000;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/fixed_sign_mag.sv
// Sign/magnitude helper for the divider. It splits both operands into a sign
// and an unsigned magnitude, and it turns a sign plus a wide magnitude back
// into a saturated two's-complement word.
module fixed_sign_mag #(
   parameter int WIDTH = 16,
   parameter int QW    = 28
) (
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   output logic             a_neg,
   output logic             b_neg,
   output logic [WIDTH-1:0] a_mag,
   output logic [WIDTH-1:0] b_mag,
   input  logic             in_neg,
   input  logic [QW-1:0]    in_q,
   output logic [WIDTH-1:0] out_val,
   output logic             out_ovf
);

   localparam logic [WIDTH-1:0] VAL_MAX = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic [WIDTH-1:0] VAL_MIN = {1'b1, {(WIDTH-1){1'b0}}};
   // Largest magnitudes that still fit: +0x7FFF and -0x8000.
   localparam logic [QW-1:0] POS_LIM = {{(QW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
   localparam logic [QW-1:0] NEG_LIM = {{(QW-WIDTH){1'b0}}, 1'b1, {(WIDTH-1){1'b0}}};

   // The most negative input maps to its true magnitude (0x8000 = 32768)
   // because the magnitude is read as unsigned.
   assign a_neg = in_a[WIDTH-1];
   assign b_neg = in_b[WIDTH-1];
   assign a_mag = a_neg ? -in_a : in_a;
   assign b_mag = b_neg ? -in_b : in_b;

   // Saturating conversion of sign + magnitude; a zero magnitude negates to +0.
   always_comb begin
      // NOTE: every output of a combinational block gets a default first, so
      // no path through the branches leaves it unassigned and infers a latch.
      out_val = '0;
      out_ovf = 1'b0;
      if (in_neg) begin
         if (in_q > NEG_LIM) begin
            out_val = VAL_MIN;
            out_ovf = 1'b1;
         end else begin
            out_val = -in_q[WIDTH-1:0];
         end
      end else begin
         if (in_q > POS_LIM) begin
            out_val = VAL_MAX;
            out_ovf = 1'b1;
         end else begin
            out_val = in_q[WIDTH-1:0];
         end
      end
   end

endmodule

// File: rtl/fixed_divide.sv
// Sequential signed Q3.12 divider: restoring long division on magnitudes,
// one quotient bit per clock, followed by sign restore and saturation.
module fixed_divide #(
   parameter int WIDTH = fixed_defs::WIDTH,
   parameter int FRAC  = fixed_defs::FRAC
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] in_A,
   input  logic [WIDTH-1:0] in_B,
   input  logic             in_En,
   output logic [WIDTH-1:0] out_Out,
   output logic             out_Ready,
   output logic             out_Busy,
   output logic             out_DivZero,
   output logic             out_Overflow
);

   import fixed_defs::*;

   localparam int N  = WIDTH + FRAC;
   localparam int CW = $clog2(N);

   state_t           state, state_next;
   logic             sign_q;     // sign of the quotient
   logic             a_neg_q;    // sign of the dividend, picks the divide-by-zero rail
   logic             dz_q;       // divisor was zero
   logic [WIDTH-1:0] b_mag_q;
   logic [WIDTH-1:0] rem_q;
   logic [N-1:0]     dq_q;       // dividend shifts out of the top, quotient in at the bottom
   logic [CW-1:0]    cnt_q;

   logic             a_neg, b_neg;
   logic [WIDTH-1:0] a_mag, b_mag;
   logic [WIDTH-1:0] sat_val;
   logic             sat_ovf;
   logic             accept;
   logic [WIDTH:0]   rem_shift, rem_diff;
   logic             rem_ge;

   // A zero divisor is treated as an infinite magnitude carrying the
   // dividend's sign, so the saturator produces the 0x7FFF/0x8000 rail.
   fixed_sign_mag #(.WIDTH(WIDTH), .QW(N)) u_sign_mag (
      .in_a    (in_A),
      .in_b    (in_B),
      .a_neg   (a_neg),
      .b_neg   (b_neg),
      .a_mag   (a_mag),
      .b_mag   (b_mag),
      .in_neg  (dz_q ? a_neg_q : sign_q),
      .in_q    (dz_q ? {N{1'b1}} : dq_q),
      .out_val (sat_val),
      .out_ovf (sat_ovf)
   );

   assign accept    = (state == IDLE) && in_En;
   assign rem_shift = {rem_q, dq_q[N-1]};
   assign rem_ge    = (rem_shift >= {1'b0, b_mag_q});
   assign rem_diff  = rem_shift - {1'b0, b_mag_q};

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_next;
   end

   // Next-state logic: IDLE -> CALC (or DONE on zero divisor) -> DONE -> IDLE.
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (in_En) state_next = (in_B == '0) ? DONE : CALC;
         CALC:    if (cnt_q == CW'(N - 1)) state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Operand capture on accept, then one restoring shift/subtract step per clock.
   always_ff @(posedge clk or negedge rst) begin
      // NOTE: clocked state uses non-blocking assignments so every register
      // samples pre-edge values, independent of statement order.
      if (!rst) begin
         sign_q  <= 1'b0;
         a_neg_q <= 1'b0;
         dz_q    <= 1'b0;
         b_mag_q <= '0;
         rem_q   <= '0;
         dq_q    <= '0;
         cnt_q   <= '0;
      end else if (accept) begin
         sign_q  <= a_neg ^ b_neg;
         a_neg_q <= a_neg;
         dz_q    <= (in_B == '0);
         b_mag_q <= b_mag;
         rem_q   <= '0;
         dq_q    <= {a_mag, {FRAC{1'b0}}};
         cnt_q   <= '0;
      end else if (state == CALC) begin
         // The kept remainder is always below |B|, so it fits in WIDTH bits.
         rem_q <= WIDTH'(rem_ge ? rem_diff : rem_shift);
         dq_q  <= {dq_q[N-2:0], rem_ge};
         cnt_q <= cnt_q + CW'(1);
      end
   end

   // Registered outputs: result and flags load in DONE, flags clear on accept.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         out_Out      <= '0;
         out_Ready    <= 1'b0;
         out_Busy     <= 1'b0;
         out_DivZero  <= 1'b0;
         out_Overflow <= 1'b0;
      end else begin
         out_Ready <= (state == DONE);
         out_Busy  <= (state_next != IDLE) || (state == DONE);
         if (accept) begin
            out_DivZero  <= 1'b0;
            out_Overflow <= 1'b0;
         end else if (state == DONE) begin
            out_Out      <= sat_val;
            out_DivZero  <= dz_q;
            out_Overflow <= sat_ovf & ~dz_q;
         end
      end
   end

endmodule

// File: tb/tb_fixed_divide.sv
// Self-checking bench for fixed_divide: expected results are queued when a
// division is started and compared when out_Ready pulses.
module tb_fixed_divide;

   import fixed_defs::*;

   typedef struct {
      logic [15:0] val;
      logic        dz;
      logic        ovf;
   } exp_t;

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic [15:0] val;
      logic        dz;
      logic        ovf;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] in_A, in_B;
   logic        in_En;
   logic [15:0] out_Out;
   logic        out_Ready, out_Busy, out_DivZero, out_Overflow;

   exp_t sb[$];
   int   compared   = 0;
   int   mismatched = 0;

   always #5 clk = ~clk;

   fixed_divide dut (
      .clk          (clk),
      .rst          (rst),
      .in_A         (in_A),
      .in_B         (in_B),
      .in_En        (in_En),
      .out_Out      (out_Out),
      .out_Ready    (out_Ready),
      .out_Busy     (out_Busy),
      .out_DivZero  (out_DivZero),
      .out_Overflow (out_Overflow)
   );

   // Reference quotient from integer arithmetic on the real values.
   function automatic exp_t model(input logic [15:0] a, input logic [15:0] b);
      exp_t        e;
      longint      ma, mb, q;
      logic [15:0] qs;
      e.val = 16'h0;
      e.dz  = 1'b0;
      e.ovf = 1'b0;
      if (b == 16'h0) begin
         e.val = a[15] ? Q_MIN : Q_MAX;
         e.dz  = 1'b1;
         return e;
      end
      ma = a[15] ? 65536 - longint'(a) : longint'(a);
      mb = b[15] ? 65536 - longint'(b) : longint'(b);
      q  = (ma * 4096) / mb;
      qs = q[15:0];
      if (a[15] ^ b[15]) begin
         if (q > 32768) begin e.val = Q_MIN; e.ovf = 1'b1; end
         else e.val = -qs;
      end else begin
         if (q > 32767) begin e.val = Q_MAX; e.ovf = 1'b1; end
         else e.val = qs;
      end
      return e;
   endfunction

   // Start one division, optionally poke a second in_En at edge k+poke_at,
   // wait for out_Ready and compare against the scoreboard.
   task automatic run_div(input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] e_val, input logic e_dz, input logic e_ovf,
                          input int poke_at, input bit post_check, input string name);
      exp_t e;
      int   lat;
      int   exp_lat;
      bit   seen;
      bit   busy_ok;
      e.val = e_val;
      e.dz  = e_dz;
      e.ovf = e_ovf;
      sb.push_back(e);
      exp_lat = (b == 16'h0) ? 1 : 29;

      @(negedge clk);
      in_A  = a;
      in_B  = b;
      in_En = 1'b1;
      @(posedge clk);
      #1;
      in_En = 1'b0;
      compared++;
      if (out_Busy !== 1'b1 || out_DivZero !== 1'b0 || out_Overflow !== 1'b0) begin
         mismatched++;
         $display("FAIL %s accept: busy=%b dz=%b ovf=%b, required busy=1 dz=0 ovf=0",
                  name, out_Busy, out_DivZero, out_Overflow);
      end

      lat     = 0;
      seen    = 1'b0;
      busy_ok = 1'b1;
      while (!seen && lat < 40) begin
         if (poke_at != 0 && lat + 1 == poke_at) begin
            @(negedge clk);
            in_A  = 16'h1000;
            in_B  = 16'h3000;
            in_En = 1'b1;
         end
         @(posedge clk);
         #1;
         in_En = 1'b0;
         lat++;
         if (out_Busy !== 1'b1) busy_ok = 1'b0;
         if (out_Ready === 1'b1) seen = 1'b1;
      end

      compared++;
      if (!seen) begin
         mismatched++;
         $display("FAIL %s timeout: no out_Ready within %0d edges", name, lat);
         e = sb.pop_front();
         return;
      end
      if (lat != exp_lat) begin
         mismatched++;
         $display("FAIL %s latency: got %0d edges, required %0d", name, lat, exp_lat);
      end

      compared++;
      if (!busy_ok) begin
         mismatched++;
         $display("FAIL %s busy: out_Busy dropped before out_Ready, required high throughout", name);
      end

      e = sb.pop_front();
      compared++;
      if ({out_Out, out_DivZero, out_Overflow} !== {e.val, e.dz, e.ovf}) begin
         mismatched++;
         $display("FAIL %s result: out=%h dz=%b ovf=%b, required out=%h dz=%b ovf=%b",
                  name, out_Out, out_DivZero, out_Overflow, e.val, e.dz, e.ovf);
      end

      if (post_check) begin
         @(posedge clk);
         #1;
         compared++;
         if (out_Ready !== 1'b0 || out_Busy !== 1'b0 || out_Out !== e.val || out_DivZero !== e.dz) begin
            mismatched++;
            $display("FAIL %s hold: ready=%b busy=%b out=%h dz=%b, required ready=0 busy=0 out=%h dz=%b",
                     name, out_Ready, out_Busy, out_Out, out_DivZero, e.val, e.dz);
         end
      end
   endtask

   task automatic test_reset();
      rst   = 1'b0;
      in_En = 1'b0;
      in_A  = 16'h0;
      in_B  = 16'h0;
      #2;
      compared++;
      if ({out_Out, out_Ready, out_Busy, out_DivZero, out_Overflow} !== 20'h0) begin
         mismatched++;
         $display("FAIL reset_initial: out=%h ready=%b busy=%b dz=%b ovf=%b, required all 0",
                  out_Out, out_Ready, out_Busy, out_DivZero, out_Overflow);
      end
      in_A  = 16'h3000;
      in_B  = 16'h2000;
      in_En = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      compared++;
      if ({out_Out, out_Ready, out_Busy, out_DivZero, out_Overflow} !== 20'h0) begin
         mismatched++;
         $display("FAIL reset_held: out=%h ready=%b busy=%b dz=%b ovf=%b, required all 0",
                  out_Out, out_Ready, out_Busy, out_DivZero, out_Overflow);
      end
      in_En = 1'b0;
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic test_basic();
      vec_t v[7];
      v[0] = '{16'h3000, 16'h2000, 16'h1800, 1'b0, 1'b0};
      v[1] = '{16'h1000, 16'h3000, 16'h0555, 1'b0, 1'b0};
      v[2] = '{16'hF000, 16'h3000, 16'hFAAB, 1'b0, 1'b0};
      v[3] = '{16'hF000, 16'h4000, 16'hFC00, 1'b0, 1'b0};
      v[4] = '{16'h7FFF, 16'h0800, 16'h7FFF, 1'b0, 1'b1};
      v[5] = '{16'h8000, 16'hF000, 16'h7FFF, 1'b0, 1'b1};
      v[6] = '{16'h8000, 16'h1000, 16'h8000, 1'b0, 1'b0};
      for (int i = 0; i < 7; i++)
         run_div(v[i].a, v[i].b, v[i].val, v[i].dz, v[i].ovf, 0, 1'b1, $sformatf("basic%0d", i));
   endtask

   task automatic test_divzero();
      run_div(16'h1234, 16'h0000, 16'h7FFF, 1'b1, 1'b0, 0, 1'b1, "divzero_pos");
      run_div(16'h9000, 16'h0000, 16'h8000, 1'b1, 1'b0, 0, 1'b1, "divzero_neg");
   endtask

   task automatic test_random();
      logic [15:0] a, b;
      exp_t        e;
      for (int i = 0; i < 6; i++) begin
         a = 16'($urandom) >> (i % 4);
         b = 16'($urandom);
         e = model(a, b);
         run_div(a, b, e.val, e.dz, e.ovf, 0, 1'b1, $sformatf("random%0d", i));
      end
   endtask

   // A second in_En at edge k+10 must be ignored; the result follows 3.0/2.0.
   task automatic test_ignore();
      run_div(16'h3000, 16'h2000, 16'h1800, 1'b0, 1'b0, 10, 1'b1, "ignore_busy");
   endtask

   // New in_En on the edge right after the out_Ready cycle; flags left by the
   // divide-by-zero must clear at that accept.
   task automatic test_back_to_back();
      run_div(16'h1234, 16'h0000, 16'h7FFF, 1'b1, 1'b0, 0, 1'b0, "b2b_first");
      run_div(16'h1000, 16'h3000, 16'h0555, 1'b0, 1'b0, 0, 1'b0, "b2b_second");
      run_div(16'hF000, 16'h4000, 16'hFC00, 1'b0, 1'b0, 0, 1'b1, "b2b_third");
   endtask

   task automatic test_abort();
      bit seen;
      @(negedge clk);
      in_A  = 16'h3000;
      in_B  = 16'h2000;
      in_En = 1'b1;
      @(posedge clk);
      #1;
      in_En = 1'b0;
      repeat (9) @(posedge clk);
      #3;
      rst = 1'b0;
      #1;
      compared++;
      if ({out_Out, out_Ready, out_Busy, out_DivZero, out_Overflow} !== 20'h0) begin
         mismatched++;
         $display("FAIL abort_async: out=%h ready=%b busy=%b dz=%b ovf=%b, required all 0",
                  out_Out, out_Ready, out_Busy, out_DivZero, out_Overflow);
      end
      @(posedge clk);
      @(negedge clk);
      rst  = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk);
         #1;
         if (out_Ready === 1'b1 || out_Busy === 1'b1) seen = 1'b1;
      end
      compared++;
      if (seen) begin
         mismatched++;
         $display("FAIL abort_no_ready: out_Ready or out_Busy seen after abort, required neither");
      end
      run_div(16'h1000, 16'h1000, ONE, 1'b0, 1'b0, 0, 1'b1, "after_abort");
   endtask

   initial begin
      test_reset();
      test_basic();
      test_divzero();
      test_random();
      test_ignore();
      test_back_to_back();
      test_abort();
      compared++;
      if (sb.size() != 0) begin
         mismatched++;
         $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
